// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared widths and accumulator limits for the MAC accumulator and the
// downstream int18-to-bf16 normalizer.
//   IN_W    : signed operand width
//   ACC_W   : signed accumulator / result width
//   ACC_MAX : largest representable accumulator value
//   ACC_MIN : smallest representable accumulator value
// -----------------------------------------------------------------------------
package tpu_pkg;

  localparam int IN_W  = 8;
  localparam int ACC_W = 18;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Finished dot product as handed to the normalizer.
  typedef struct packed {
    logic signed [ACC_W-1:0] value;
    logic                    sat;
  } acc_result_t;

endpackage

// File: rtl/sat_add_acc.sv
// -----------------------------------------------------------------------------
// sat_add_acc
// Combinational saturating adder: sum = clamp(acc + sign_extend(product)).
// Ports:
//   acc     (in)  : signed accumulator operand, ACC_W bits
//   product (in)  : signed product operand, PROD_W bits
//   sum     (out) : saturated signed result, ACC_W bits
//   ovf     (out) : high when the exact sum fell outside the ACC_W range
// -----------------------------------------------------------------------------
module sat_add_acc #(
  parameter int ACC_W  = 18,
  parameter int PROD_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] product,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  // One guard bit above the wider operand makes the exact sum unable to wrap.
  localparam int SW = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] prod_ext;
  logic signed [SW-1:0] wide;
  logic signed [SW-1:0] max_w;
  logic signed [SW-1:0] min_w;

  assign acc_ext  = {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
  assign prod_ext = {{(SW-PROD_W){product[PROD_W-1]}}, product};
  assign wide     = acc_ext + prod_ext;
  assign max_w    = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  assign min_w    = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Clamp the exact sum into the accumulator range and flag any clipping.
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    if (wide > max_w) begin
      sum = max_w[ACC_W-1:0];
      ovf = 1'b1;
    end else if (wide < min_w) begin
      sum = min_w[ACC_W-1:0];
      ovf = 1'b1;
    end else begin
      sum = wide[ACC_W-1:0];
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/mac_accum_int18.sv
// -----------------------------------------------------------------------------
// mac_accum_int18
// Two-stage signed multiply-accumulate producing saturated dot products.
// Stage 1 registers a*b; stage 2 adds it into the running accumulator and, on
// the last term, publishes the result on a valid/ready output register.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready is the pipeline enable)
//   a, b              : signed IN_W-bit operands
//   in_last           : pair is the final term of the current dot product
//   out_valid/out_ready : result handshake
//   acc_out           : signed ACC_W-bit dot product
//   out_sat           : saturation occurred at least once in acc_out
// -----------------------------------------------------------------------------
module mac_accum_int18 #(
  parameter int IN_W  = tpu_pkg::IN_W,
  parameter int ACC_W = tpu_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_sat
);

  import tpu_pkg::*;

  localparam int PROD_W = 2 * IN_W;

  logic                     en;
  logic                     s1_valid;
  logic                     s1_last;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;
  logic                     sat_sticky;
  logic                     sticky_merged;
  logic                     first;
  logic                     ovf;
  logic                     write_term;
  logic                     write_last;

  // The whole pipeline freezes only while a finished result is being refused.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  assign write_term = en && s1_valid;
  assign write_last = write_term && s1_last;

  // A new dot product ignores whatever the accumulator and sticky flag hold.
  always_comb begin
    acc_base      = '0;
    sticky_merged = 1'b0;
    if (first) begin
      acc_base      = '0;
      sticky_merged = ovf;
    end else begin
      acc_base      = acc;
      sticky_merged = sat_sticky | ovf;
    end
  end

  sat_add_acc #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc     (acc_base),
    .product (s1_prod),
    .sum     (sum),
    .ovf     (ovf)
  );

  // Stage 1: register the full-width product with its valid and last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_prod  <= PROD_W'(a) * PROD_W'(b);
    end
  end

  // Stage 2 accumulator: running sum, sticky saturation and first-term flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      sat_sticky <= 1'b0;
      first      <= 1'b1;
    end else if (write_term) begin
      if (s1_last) begin
        acc        <= '0;
        sat_sticky <= 1'b0;
        first      <= 1'b1;
      end else begin
        acc        <= sum;
        sat_sticky <= sticky_merged;
        first      <= 1'b0;
      end
    end
  end

  // Output register: when enabled the old result has been taken (or there was
  // none), so out_valid simply follows whether a last term lands this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= write_last;
      if (write_last) begin
        acc_out <= sum;
        out_sat <= sticky_merged;
      end
    end
  end

endmodule

// File: tb/tb_mac_accum_int18.sv
// -----------------------------------------------------------------------------
// tb_mac_accum_int18
// Scoreboard bench: stimulus pushes expected dot products into a queue and a
// negedge monitor pops and compares each result accepted downstream.
// -----------------------------------------------------------------------------
module tb_mac_accum_int18;

  import tpu_pkg::*;

  localparam int IW   = IN_W;
  localparam int AW   = ACC_W;
  localparam int MAXV = (1 << (AW - 1)) - 1;
  localparam int MINV = -(1 << (AW - 1));

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] a;
  logic signed [IW-1:0] b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] acc_out;
  logic                 out_sat;

  typedef struct {
    int value;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   n_pushed   = 0;
  int   n_popped   = 0;
  int   cyc        = 0;
  int   ready_mode = 0;
  int   m_acc;
  bit   m_sat;
  bit   m_first;

  mac_accum_int18 #(.IN_W(IW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int v, input bit s);
    exp_t e;
    e.value = v;
    e.sat   = s;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Reference: saturating accumulate of one term; pushes on the last term.
  task automatic model_term(input int av, input int bv, input bit last);
    int s;
    bit o;
    s = (m_first ? 0 : m_acc) + av * bv;
    o = 1'b0;
    if (s > MAXV) begin
      s = MAXV;
      o = 1'b1;
    end else if (s < MINV) begin
      s = MINV;
      o = 1'b1;
    end
    if (last) begin
      push_exp(s, (m_first ? 1'b0 : m_sat) | o);
      m_acc   = 0;
      m_sat   = 1'b0;
      m_first = 1'b1;
    end else begin
      m_sat   = (m_first ? 1'b0 : m_sat) | o;
      m_acc   = s;
      m_first = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int av, input int bv, input bit last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a        = IW'(av);
    b        = IW'(bv);
    in_last  = last;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: a result is consumed on the next edge when valid and ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      n_popped++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %0d, expected no result", int'(acc_out));
      end else begin
        e = exp_q.pop_front();
        check("acc_out", int'(acc_out), e.value);
        check("out_sat", int'(out_sat), int'(e.sat));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time got 400000, expected completion earlier");
    $fatal(1);
  end

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    a        = '0;
    b        = '0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_acc_out", int'(acc_out), 0);
    check("reset_out_sat", out_sat, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Three-term dot product and its two-edge latency.
    push_exp(16111, 1'b0);
    send(3, 4, 1'b0);
    send(5, -6, 1'b0);
    send(127, 127, 1'b1);
    check("latency_edge1_out_valid", out_valid, 0);
    idle(1);
    check("latency_edge2_out_valid", out_valid, 1);
    drain();
    idle(2);

    // Positive saturation, then a clean single-term product.
    push_exp(131071, 1'b1);
    repeat (8) send(-128, -128, 1'b0);
    send(-128, -128, 1'b1);
    push_exp(1, 1'b0);
    send(1, 1, 1'b1);
    idle(1);
    drain();
    idle(2);

    // Back-to-back single-term products on consecutive cycles.
    base = pop_cyc.size();
    push_exp(6, 1'b0);
    push_exp(20, 1'b0);
    push_exp(-7, 1'b0);
    send(2, 3, 1'b1);
    send(4, 5, 1'b1);
    send(-1, 7, 1'b1);
    idle(1);
    drain();
    idle(2);
    if (pop_cyc.size() >= base + 3) begin
      check("b2b_gap_1", pop_cyc[base+1] - pop_cyc[base], 1);
      check("b2b_gap_2", pop_cyc[base+2] - pop_cyc[base+1], 1);
    end else begin
      check("b2b_result_count", pop_cyc.size() - base, 3);
    end

    // Downstream stall: pipeline freezes with a pair waiting at the input.
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    push_exp(4, 1'b0);
    push_exp(9, 1'b0);
    push_exp(2, 1'b0);
    send(2, 2, 1'b1);
    send(3, 3, 1'b1);
    in_valid = 1'b1;
    a        = 8'sd1;
    b        = 8'sd1;
    in_last  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_acc_out", int'(acc_out), 4);
      @(negedge clk);
    end
    ready_mode = 0;
    send(1, 1, 1'b0);
    send(1, 1, 1'b1);
    idle(1);
    drain();
    idle(2);

    // Reset in the middle of an accumulation discards the partial sum.
    send(1, 1, 1'b0);
    send(2, 2, 1'b0);
    send(3, 3, 1'b0);
    idle(0);
    #2;
    rst = 1'b1;
    #1;
    check("midacc_rst_out_valid", out_valid, 0);
    check("midacc_rst_in_ready", in_ready, 1);
    check("midacc_rst_acc_out", int'(acc_out), 0);
    check("midacc_rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(100, 1'b0);
    send(10, 10, 1'b1);
    idle(1);
    drain();
    idle(2);

    // Reset while a result is held by a stalled downstream.
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    send(7, 7, 1'b1);
    idle(3);
    check("stall_hold_out_valid", out_valid, 1);
    check("stall_hold_acc_out", int'(acc_out), 49);
    #2;
    rst = 1'b1;
    #1;
    check("stall_rst_out_valid", out_valid, 0);
    check("stall_rst_in_ready", in_ready, 1);
    check("stall_rst_acc_out", int'(acc_out), 0);
    check("stall_rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst        = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    push_exp(-9, 1'b0);
    send(3, -3, 1'b1);
    idle(1);
    drain();
    idle(2);

    // Random streams with input gaps and random downstream ready.
    m_acc      = 0;
    m_sat      = 1'b0;
    m_first    = 1'b1;
    ready_mode = 1;
    for (int i = 0; i < 80; i++) begin
      int av;
      int bv;
      bit last;
      if ($urandom_range(0, 1) == 1) begin
        av = ($urandom_range(0, 1) == 1) ? -128 : 127;
        bv = ($urandom_range(0, 1) == 1) ? -128 : 127;
      end else begin
        av = int'($urandom_range(0, 255)) - 128;
        bv = int'($urandom_range(0, 255)) - 128;
      end
      last = (i == 79) || ($urandom_range(0, 5) == 0);
      model_term(av, bv, last);
      send(av, bv, last);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    ready_mode = 0;
    drain();
    idle(4);
    check("results_popped_vs_pushed", n_popped, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
